axi_master_arbiter: RTL
=======================

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 Parameters SHALL be:
- M_WIDTH, default 2, log2 of master count N = 2**M_WIDTH.
- ID_WIDTH, default 4, bus ID width; the top M_WIDTH ID bits carry the master index.
- WFIFO_DEPTH, default 4, write-order FIFO depth; power of 2, >= 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- m_wr_addr_valid, in, N, per-master AW valid.
- m_rd_addr_valid, in, N, per-master AR valid.
- bus_wr_addr_valid, in, 1, bus AW valid.
- bus_wr_addr_ready, in, 1, bus AW ready.
- bus_wr_data_valid, in, 1, bus W valid.
- bus_wr_data_ready, in, 1, bus W ready.
- bus_wr_data_last, in, 1, bus W last.
- bus_wr_back_id, in, ID_WIDTH, bus B ID.
- bus_rd_addr_valid, in, 1, bus AR valid.
- bus_rd_addr_ready, in, 1, bus AR ready.
- bus_rd_back_id, in, ID_WIDTH, bus R ID.
- wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel, out, M_WIDTH each, switch selects.
- wr_addr_grant, out, 1, AW lock active; integration gates bus AW valid with it.
- rd_addr_grant, out, 1, AR lock active; integration gates bus AR valid with it.
- wr_data_en, out, 1, W routing valid; integration gates bus W valid with it.
- wfifo_full, out, 1, write-order FIFO full.

Function
REQ-003 AW arbiter SHALL be a 2-state FSM, IDLE/LOCK; wr_addr_grant = (state==LOCK).
REQ-004 In IDLE, if any m_wr_addr_valid bit is set and wfifo_full==0:
- Pick the first requester in round-robin order starting at aw_last+1 mod N.
- Register its index into wr_addr_sel and go to LOCK.
- Request at cycle k gives the grant at cycle k+1.
REQ-005 In LOCK, wr_addr_sel SHALL hold until an AW handshake (bus_wr_addr_valid & bus_wr_addr_ready). On that edge the arbiter SHALL:
- Push wr_addr_sel into the write-order FIFO.
- Set aw_last = wr_addr_sel.
- Return to IDLE.
REQ-006 LOCK SHALL persist if the granted master drops valid without a handshake. There is no timeout.
REQ-007 Minimum AW grant spacing SHALL be 2 cycles per burst (LOCK -> IDLE -> LOCK).
REQ-008 AR arbiter SHALL be an independent identical FSM:
- Uses m_rd_addr_valid, rd_addr_sel, rd_addr_grant and ar_last.
- Has no FIFO-full gating.
REQ-009 Write-order FIFO output mapping:
- wr_data_sel = FIFO head.
- wr_data_en = FIFO non-empty.
- wfifo_full = (count == WFIFO_DEPTH).
REQ-010 FIFO pop SHALL occur on wr_data_en & bus_wr_data_valid & bus_wr_data_ready & bus_wr_data_last. Non-last beats SHALL NOT pop.
REQ-011 FIFO timing and boundaries:
- Simultaneous push and pop SHALL keep the count unchanged.
- A push into an empty FIFO SHALL make the head visible the next cycle.
- Pointers wrap modulo WFIFO_DEPTH.
- Count width is clog2(WFIFO_DEPTH)+1.
REQ-012 When the FIFO is full, no new AW grant SHALL issue. A pop in the same cycle does not unblock it; arbitration resumes the cycle after the count drops.
REQ-013 wr_resp_sel SHALL equal bus_wr_back_id[ID_WIDTH-1 -: M_WIDTH] (combinational, zero latency). rd_data_sel SHALL equal bus_rd_back_id[ID_WIDTH-1 -: M_WIDTH], likewise.
REQ-014 W beats while wr_data_en==0 are not routed; write data ahead of address is unsupported.

Reset
REQ-015 rstn low SHALL asynchronously force:
- Both FSMs to IDLE.
- All registered selects to 0 and both grants to 0.
- FIFO empty, so wr_data_en=0 and wfifo_full=0.
- aw_last and ar_last to N-1, giving master 0 first priority.
REQ-016 Reset mid-burst SHALL discard all in-flight ordering state. Release is synchronous to the next clk edge with rstn high.

Verification
REQ-017 After reset, m_wr_addr_valid=4'b1111 with ready always 1 -> wr_addr_sel grant order 0,1,2,3,0; FIFO receives 0,1,2,3.
REQ-018 Master 2 AW granted, bus_wr_addr_ready low 5 cycles -> wr_addr_sel stays 2 and wr_addr_grant stays 1 all 5 cycles; push occurs on the ready cycle.
REQ-019 WFIFO_DEPTH=4, four AW handshakes with bus_wr_data_valid=0 -> wfifo_full=1 and no fifth grant; one last-beat pop -> grant resumes the following cycle.
REQ-020 AW masters 1 then 3 handshaken; 4-beat bursts on W -> wr_data_sel=1 until the last beat of burst 1, then 3; wr_data_en falls after burst 3.
REQ-021 bus_wr_back_id=4'b1001, bus_rd_back_id=4'b0110 -> wr_resp_sel=2, rd_data_sel=1 in the same cycle.
REQ-022 rstn asserted while AW is in LOCK with 2 FIFO entries -> grants 0, wr_data_en 0 and selects 0 immediately; the next request from master 0 is granted first.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// Per-channel AXI master arbiter: round-robin AW/AR address locks plus a
// write-order FIFO that steers W beats, and ID-decoded B/R return selects.
module axi_master_arbiter #(
  parameter int M_WIDTH     = 2,
  parameter int ID_WIDTH    = 4,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2**M_WIDTH-1:0]   m_wr_addr_valid,
  input  logic [2**M_WIDTH-1:0]   m_rd_addr_valid,
  input  logic                    bus_wr_addr_valid,
  input  logic                    bus_wr_addr_ready,
  input  logic                    bus_wr_data_valid,
  input  logic                    bus_wr_data_ready,
  input  logic                    bus_wr_data_last,
  input  logic [ID_WIDTH-1:0]     bus_wr_back_id,
  input  logic                    bus_rd_addr_valid,
  input  logic                    bus_rd_addr_ready,
  input  logic [ID_WIDTH-1:0]     bus_rd_back_id,
  output logic [M_WIDTH-1:0]      wr_addr_sel,
  output logic [M_WIDTH-1:0]      wr_data_sel,
  output logic [M_WIDTH-1:0]      wr_resp_sel,
  output logic [M_WIDTH-1:0]      rd_addr_sel,
  output logic [M_WIDTH-1:0]      rd_data_sel,
  output logic                    wr_addr_grant,
  output logic                    rd_addr_grant,
  output logic                    wr_data_en,
  output logic                    wfifo_full
);

  localparam int N  = 2**M_WIDTH;
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]      FULL_CNT = CW'(WFIFO_DEPTH);
  localparam logic [M_WIDTH-1:0] LAST_RST = M_WIDTH'(N - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_state_e;

  // Descending scan so the requester closest after 'last' wins.
  function automatic logic [M_WIDTH-1:0] rr_pick(input logic [N-1:0] req,
                                                 input logic [M_WIDTH-1:0] last);
    logic [M_WIDTH-1:0] idx;
    rr_pick = last;
    for (int i = N; i >= 1; i--) begin
      idx = last + M_WIDTH'(i);
      if (req[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  arb_state_e         aw_state_q, aw_state_d, ar_state_q, ar_state_d;
  logic [M_WIDTH-1:0] aw_sel_q, aw_sel_d, aw_last_q, aw_last_d;
  logic [M_WIDTH-1:0] ar_sel_q, ar_sel_d, ar_last_q, ar_last_d;
  logic [M_WIDTH-1:0] mem_q [WFIFO_DEPTH];
  logic [M_WIDTH-1:0] mem_d [WFIFO_DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               aw_push_s, w_pop_s;
  logic               unused_id_s;

  assign wr_addr_sel   = aw_sel_q;
  assign rd_addr_sel   = ar_sel_q;
  assign wr_addr_grant = (aw_state_q == ST_LOCK);
  assign rd_addr_grant = (ar_state_q == ST_LOCK);
  assign wr_data_sel   = mem_q[rptr_q];
  assign wr_data_en    = (count_q != {CW{1'b0}});
  assign wfifo_full    = (count_q == FULL_CNT);
  assign wr_resp_sel   = bus_wr_back_id[ID_WIDTH-1 -: M_WIDTH];
  assign rd_data_sel   = bus_rd_back_id[ID_WIDTH-1 -: M_WIDTH];
  assign unused_id_s   = ^{bus_wr_back_id, bus_rd_back_id};
  assign w_pop_s       = wr_data_en & bus_wr_data_valid & bus_wr_data_ready & bus_wr_data_last;

  // AW lock: new grants are held off while the write-order FIFO is full.
  always_comb begin
    aw_state_d = aw_state_q;
    aw_sel_d   = aw_sel_q;
    aw_last_d  = aw_last_q;
    aw_push_s  = 1'b0;
    case (aw_state_q)
      ST_IDLE: begin
        if ((|m_wr_addr_valid) && !wfifo_full) begin
          aw_sel_d   = rr_pick(m_wr_addr_valid, aw_last_q);
          aw_state_d = ST_LOCK;
        end else begin
          aw_state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (bus_wr_addr_valid && bus_wr_addr_ready) begin
          aw_push_s  = 1'b1;
          aw_last_d  = aw_sel_q;
          aw_state_d = ST_IDLE;
        end else begin
          aw_state_d = ST_LOCK;
        end
      end
      default: aw_state_d = ST_IDLE;
    endcase
  end

  // AR lock: same round-robin scheme, no downstream back-pressure.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_sel_d   = ar_sel_q;
    ar_last_d  = ar_last_q;
    case (ar_state_q)
      ST_IDLE: begin
        if (|m_rd_addr_valid) begin
          ar_sel_d   = rr_pick(m_rd_addr_valid, ar_last_q);
          ar_state_d = ST_LOCK;
        end else begin
          ar_state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (bus_rd_addr_valid && bus_rd_addr_ready) begin
          ar_last_d  = ar_sel_q;
          ar_state_d = ST_IDLE;
        end else begin
          ar_state_d = ST_LOCK;
        end
      end
      default: ar_state_d = ST_IDLE;
    endcase
  end

  // Write-order FIFO: push on AW handshake, pop on the last W beat only.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (aw_push_s) begin
      mem_d[wptr_q] = aw_sel_q;
      wptr_d        = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (w_pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({aw_push_s, w_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset biases both arbiters toward master 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_state_q <= ST_IDLE;
      ar_state_q <= ST_IDLE;
      aw_sel_q   <= {M_WIDTH{1'b0}};
      ar_sel_q   <= {M_WIDTH{1'b0}};
      aw_last_q  <= LAST_RST;
      ar_last_q  <= LAST_RST;
      mem_q      <= '{default: {M_WIDTH{1'b0}}};
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      aw_state_q <= aw_state_d;
      ar_state_q <= ar_state_d;
      aw_sel_q   <= aw_sel_d;
      ar_sel_q   <= ar_sel_d;
      aw_last_q  <= aw_last_d;
      ar_last_q  <= ar_last_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

endmodule
